// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the RV32I general-purpose register file.
//   REG_NUM_DEF / DATA_W_DEF : default register count and register width
//   REG_ADDR_W               : register address width (5 bits for 32 regs)
//   ZERO_WORD                : all-zero data word
//   bypass_src_t             : which source a read port is returning
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int REG_NUM_DEF = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int REG_ADDR_W  = 5;

    localparam logic [DATA_W_DEF-1:0] ZERO_WORD = '0;

    // Source selected for a read port, from highest to lowest priority
    // (SRC_ZERO covers inactive reads and x0).
    typedef enum logic [2:0] {
        SRC_ZERO,
        SRC_EX,
        SRC_MEM,
        SRC_WB,
        SRC_ARRAY
    } bypass_src_t;

endpackage

// File: rtl/regfile_bypass.sv
// ---------------------------------------------------------------------------
// regfile_bypass
// Combinational operand selection for one decode read port. Picks the
// youngest in-flight result for the requested register (EX, then MEM, then
// WB) and falls back to the stored array word. Flags a hazard when the
// selected producer is a load whose data is not yet available.
//   read_flag / read_addr          : read request and register address
//   ex_* / mem_* / wb_*            : per-stage write enable, address, data
//   ex_is_load                     : EX result is a load (data not valid)
//   mem_pending                    : MEM load data has not returned
//   array_word                     : regs[read_addr] from the storage array
//   read_data                      : selected operand
//   hazard                         : operand unavailable, decode must hold
// ---------------------------------------------------------------------------
module regfile_bypass
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              read_flag,
    input  logic [ADDR_W-1:0] read_addr,
    input  logic              ex_wen,
    input  logic [ADDR_W-1:0] ex_waddr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic              ex_is_load,
    input  logic              mem_wen,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_pending,
    input  logic              wb_wen,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic [DATA_W-1:0] array_word,
    output logic [DATA_W-1:0] read_data,
    output logic              hazard
);

    logic        active;
    logic        ex_hit;
    logic        mem_hit;
    logic        wb_hit;
    bypass_src_t src;

    // A stage only matches when it writes a real register; a write aimed at
    // x0 must never shadow anything, even if the read address is also 0.
    assign active  = read_flag && (read_addr != '0);
    assign ex_hit  = active && ex_wen  && (ex_waddr  != '0) && (ex_waddr  == read_addr);
    assign mem_hit = active && mem_wen && (mem_waddr != '0) && (mem_waddr == read_addr);
    assign wb_hit  = active && wb_wen  && (wb_waddr  != '0) && (wb_waddr  == read_addr);

    // Priority select: the youngest producer wins so decode always sees the
    // value that program order says it should.
    always_comb begin
        src = SRC_ZERO;
        if (!active) begin
            src = SRC_ZERO;
        end else if (ex_hit) begin
            src = SRC_EX;
        end else if (mem_hit) begin
            src = SRC_MEM;
        end else if (wb_hit) begin
            src = SRC_WB;
        end else begin
            src = SRC_ARRAY;
        end
    end

    // Map the chosen source onto the data output. During a hazard this is
    // still the selected (stale) word; decode is told not to consume it.
    always_comb begin
        read_data = '0;
        case (src)
            SRC_EX:    read_data = ex_wdata;
            SRC_MEM:   read_data = mem_wdata;
            SRC_WB:    read_data = wb_wdata;
            SRC_ARRAY: read_data = array_word;
            default:   read_data = '0;
        endcase
    end

    // A MEM-stage load only blocks when no younger EX result shadows it.
    assign hazard = (ex_hit && ex_is_load) || (!ex_hit && mem_hit && mem_pending);

endmodule

// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile
// 32 x 32-bit RV32I register file, x0 hardwired to zero. Two combinational
// read ports with EX/MEM/WB forwarding, one write-back write port, and a
// load-use stall request.
//   clk_in, rst_in (sync, active-low), rdy_in (low freezes array writes)
//   read_flag_1/2, reg_read_1/2 -> read_data_1/2
//   ex_wen/ex_waddr/ex_wdata/ex_is_load    : EX-stage result
//   mem_wen/mem_waddr/mem_wdata/mem_pending: MEM-stage result
//   wb_wen/wb_waddr/wb_wdata               : write-back port
//   stall_req                              : decode must hold
// ---------------------------------------------------------------------------
module regfile
    import regfile_pkg::*;
#(
    parameter int REG_NUM = REG_NUM_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    localparam int ADDR_W = $clog2(REG_NUM)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              read_flag_1,
    input  logic [ADDR_W-1:0] reg_read_1,
    output logic [DATA_W-1:0] read_data_1,
    input  logic              read_flag_2,
    input  logic [ADDR_W-1:0] reg_read_2,
    output logic [DATA_W-1:0] read_data_2,
    input  logic              ex_wen,
    input  logic [ADDR_W-1:0] ex_waddr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic              ex_is_load,
    input  logic              mem_wen,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_pending,
    input  logic              wb_wen,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    output logic              stall_req
);

    // x0 is not stored; index 0 is decoded to zero before reaching the array.
    logic [DATA_W-1:0] regs [1:REG_NUM-1];

    logic [DATA_W-1:0] array_word_1;
    logic [DATA_W-1:0] array_word_2;
    logic [DATA_W-1:0] byp_data_1;
    logic [DATA_W-1:0] byp_data_2;
    logic              hazard_1;
    logic              hazard_2;

    // Storage update. Reset wins over any write in the same cycle; rdy_in low
    // freezes the array while reads and forwarding keep working.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 1; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (rdy_in && wb_wen && (wb_waddr != '0)) begin
            regs[wb_waddr] <= wb_wdata;
        end
    end

    assign array_word_1 = (reg_read_1 == '0) ? '0 : regs[reg_read_1];
    assign array_word_2 = (reg_read_2 == '0) ? '0 : regs[reg_read_2];

    regfile_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bypass_1 (
        .read_flag   (read_flag_1),
        .read_addr   (reg_read_1),
        .ex_wen      (ex_wen),
        .ex_waddr    (ex_waddr),
        .ex_wdata    (ex_wdata),
        .ex_is_load  (ex_is_load),
        .mem_wen     (mem_wen),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .mem_pending (mem_pending),
        .wb_wen      (wb_wen),
        .wb_waddr    (wb_waddr),
        .wb_wdata    (wb_wdata),
        .array_word  (array_word_1),
        .read_data   (byp_data_1),
        .hazard      (hazard_1)
    );

    regfile_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bypass_2 (
        .read_flag   (read_flag_2),
        .read_addr   (reg_read_2),
        .ex_wen      (ex_wen),
        .ex_waddr    (ex_waddr),
        .ex_wdata    (ex_wdata),
        .ex_is_load  (ex_is_load),
        .mem_wen     (mem_wen),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .mem_pending (mem_pending),
        .wb_wen      (wb_wen),
        .wb_waddr    (wb_waddr),
        .wb_wdata    (wb_wdata),
        .array_word  (array_word_2),
        .read_data   (byp_data_2),
        .hazard      (hazard_2)
    );

    // While reset is held the outputs are forced quiet, so a stall in
    // progress drops in the same cycle reset is asserted.
    assign read_data_1 = rst_in ? byp_data_1 : '0;
    assign read_data_2 = rst_in ? byp_data_2 : '0;
    assign stall_req   = rst_in && (hazard_1 || hazard_2);

endmodule

// File: tb/tb_regfile.sv
// ---------------------------------------------------------------------------
// tb_regfile
// Directed testbench for regfile. Inputs change just after the falling edge,
// outputs are compared 1 ns later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_regfile;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        read_flag_1;
    logic [4:0]  reg_read_1;
    logic [31:0] read_data_1;
    logic        read_flag_2;
    logic [4:0]  reg_read_2;
    logic [31:0] read_data_2;
    logic        ex_wen;
    logic [4:0]  ex_waddr;
    logic [31:0] ex_wdata;
    logic        ex_is_load;
    logic        mem_wen;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_pending;
    logic        wb_wen;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        stall_req;

    int total_count = 0;
    int bad_count   = 0;

    regfile dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .read_flag_1 (read_flag_1),
        .reg_read_1  (reg_read_1),
        .read_data_1 (read_data_1),
        .read_flag_2 (read_flag_2),
        .reg_read_2  (reg_read_2),
        .read_data_2 (read_data_2),
        .ex_wen      (ex_wen),
        .ex_waddr    (ex_waddr),
        .ex_wdata    (ex_wdata),
        .ex_is_load  (ex_is_load),
        .mem_wen     (mem_wen),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .mem_pending (mem_pending),
        .wb_wen      (wb_wen),
        .wb_waddr    (wb_waddr),
        .wb_wdata    (wb_wdata),
        .stall_req   (stall_req)
    );

    // 10 ns free-running clock.
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total_count++;
        if (observed !== expected) begin
            bad_count++;
            $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic clearStages();
        ex_wen = 1'b0;  ex_waddr = '0;  ex_wdata = '0;  ex_is_load = 1'b0;
        mem_wen = 1'b0; mem_waddr = '0; mem_wdata = '0; mem_pending = 1'b0;
        wb_wen = 1'b0;  wb_waddr = '0;  wb_wdata = '0;
    endtask

    // Set both read ports, then let the combinational paths settle.
    task automatic applyStimulus(input logic f1, input logic [4:0] a1,
                                 input logic f2, input logic [4:0] a2);
        read_flag_1 = f1; reg_read_1 = a1;
        read_flag_2 = f2; reg_read_2 = a2;
        #1;
    endtask

    task automatic stepClock();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    initial begin
        rst_in = 1'b0;
        rdy_in = 1'b1;
        clearStages();
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0);
        stepClock();
        stepClock();

        // Reset held: outputs stay quiet even with a forwarding load present.
        ex_wen = 1'b1; ex_waddr = 5'd5; ex_wdata = 32'hFFFF_FFFF; ex_is_load = 1'b1;
        applyStimulus(1'b1, 5'd5, 1'b1, 5'd5);
        checkOutput("rst_data1", read_data_1, 32'h0);
        checkOutput("rst_stall", {31'b0, stall_req}, 32'h0);

        // Leave reset, array reads zero.
        rst_in = 1'b1;
        clearStages();
        applyStimulus(1'b1, 5'd5, 1'b1, 5'd5);
        checkOutput("x5_p1", read_data_1, 32'h0);
        checkOutput("x5_p2", read_data_2, 32'h0);

        // Write to x0 is discarded, both forwarded and stored.
        wb_wen = 1'b1; wb_waddr = 5'd0; wb_wdata = 32'hDEAD_BEEF;
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd0);
        checkOutput("x0_byp", read_data_1, 32'h0);
        stepClock();
        clearStages();
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd0);
        checkOutput("x0_arr", read_data_1, 32'h0);

        // WB write forwarded in cycle N, read from array in N+1.
        wb_wen = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h1234_5678;
        applyStimulus(1'b1, 5'd3, 1'b0, 5'd0);
        checkOutput("x3_byp", read_data_1, 32'h1234_5678);
        stepClock();
        clearStages();
        applyStimulus(1'b1, 5'd3, 1'b1, 5'd3);
        checkOutput("x3_arr_p1", read_data_1, 32'h1234_5678);
        checkOutput("x3_arr_p2", read_data_2, 32'h1234_5678);

        // EX beats MEM beats WB; array takes the WB value.
        ex_wen = 1'b1;  ex_waddr = 5'd7;  ex_wdata = 32'h1;
        mem_wen = 1'b1; mem_waddr = 5'd7; mem_wdata = 32'h2;
        wb_wen = 1'b1;  wb_waddr = 5'd7;  wb_wdata = 32'h3;
        applyStimulus(1'b1, 5'd7, 1'b1, 5'd7);
        checkOutput("x7_ex_p1", read_data_1, 32'h1);
        checkOutput("x7_ex_p2", read_data_2, 32'h1);
        ex_wen = 1'b0;
        applyStimulus(1'b1, 5'd7, 1'b0, 5'd7);
        checkOutput("x7_mem", read_data_1, 32'h2);
        checkOutput("flag_off", read_data_2, 32'h0);
        stepClock();
        clearStages();
        applyStimulus(1'b1, 5'd7, 1'b0, 5'd0);
        checkOutput("x7_arr", read_data_1, 32'h3);

        // Load in EX: stall only for a port reading its destination.
        ex_wen = 1'b1; ex_waddr = 5'd9; ex_wdata = 32'hBAD0_BAD0; ex_is_load = 1'b1;
        applyStimulus(1'b0, 5'd0, 1'b1, 5'd9);
        checkOutput("ld_ex_stall", {31'b0, stall_req}, 32'h1);
        applyStimulus(1'b1, 5'd11, 1'b1, 5'd10);
        checkOutput("ld_ex_other", {31'b0, stall_req}, 32'h0);
        applyStimulus(1'b0, 5'd9, 1'b0, 5'd9);
        checkOutput("ld_ex_noflag", {31'b0, stall_req}, 32'h0);

        // Load moves to MEM with data pending, then data returns.
        clearStages();
        mem_wen = 1'b1; mem_waddr = 5'd9; mem_wdata = 32'h0BAD_0BAD; mem_pending = 1'b1;
        applyStimulus(1'b1, 5'd9, 1'b0, 5'd0);
        checkOutput("ld_mem_stall", {31'b0, stall_req}, 32'h1);
        mem_pending = 1'b0; mem_wdata = 32'h0000_0099;
        applyStimulus(1'b1, 5'd9, 1'b0, 5'd0);
        checkOutput("ld_mem_clear", {31'b0, stall_req}, 32'h0);
        checkOutput("ld_mem_data", read_data_1, 32'h0000_0099);

        // Non-load EX result shadows a pending MEM load.
        mem_pending = 1'b1;
        ex_wen = 1'b1; ex_waddr = 5'd9; ex_wdata = 32'h0000_00E9; ex_is_load = 1'b0;
        applyStimulus(1'b1, 5'd9, 1'b0, 5'd0);
        checkOutput("ex_shadow_stall", {31'b0, stall_req}, 32'h0);
        checkOutput("ex_shadow_data", read_data_1, 32'h0000_00E9);
        clearStages();

        // rdy_in low: forwarding still works but the array is not written.
        rdy_in = 1'b0;
        wb_wen = 1'b1; wb_waddr = 5'd4; wb_wdata = 32'h0000_00AA;
        applyStimulus(1'b1, 5'd4, 1'b0, 5'd0);
        checkOutput("rdy_byp", read_data_1, 32'h0000_00AA);
        stepClock();
        rdy_in = 1'b1;
        clearStages();
        applyStimulus(1'b1, 5'd4, 1'b0, 5'd0);
        checkOutput("rdy_frozen", read_data_1, 32'h0);

        // Reset during an active stall.
        ex_wen = 1'b1; ex_waddr = 5'd9; ex_wdata = 32'h5; ex_is_load = 1'b1;
        applyStimulus(1'b1, 5'd9, 1'b1, 5'd3);
        checkOutput("pre_rst_stall", {31'b0, stall_req}, 32'h1);
        checkOutput("pre_rst_x3", read_data_2, 32'h1234_5678);
        rst_in = 1'b0;
        #1;
        checkOutput("rst_stall_drop", {31'b0, stall_req}, 32'h0);
        checkOutput("rst_data2", read_data_2, 32'h0);
        stepClock();
        rst_in = 1'b1;
        clearStages();
        applyStimulus(1'b1, 5'd3, 1'b1, 5'd7);
        checkOutput("cleared_x3", read_data_1, 32'h0);
        checkOutput("cleared_x7", read_data_2, 32'h0);

        $display("test done: total=%0d bad=%0d", total_count, bad_count);
        $finish;
    end

endmodule

// File: doc/regfile.md
# regfile

General-purpose register file for the EPU RV32I pipeline: 32 x 32-bit registers (x0 hardwired to zero) serving the two decode-stage read ports and the single write-back write port. Reads are combinational and forward in-flight results from EX, MEM and WB, so decode sees current operands in the same cycle. Raises a stall request on load-use hazards that bypassing cannot resolve.

## Interface
- REG_NUM, 32, number of architectural registers (address width 5)
- DATA_W, 32, register width
- clk_in  in  1  system clock, all state updates on rising edge
- rst_in  in  1  reset, synchronous, active-low
- rdy_in  in  1  global enable; low freezes all register writes
- read_flag_1  in  1  port 1 read request from decode
- reg_read_1  in  5  port 1 register address
- read_data_1  out  32  port 1 data
- read_flag_2  in  1  port 2 read request from decode
- reg_read_2  in  5  port 2 register address
- read_data_2  out  32  port 2 data
- ex_wen / ex_waddr / ex_wdata  in  1/5/32  EX-stage result destined for rd
- ex_is_load  in  1  EX holds a load; ex_wdata not valid
- mem_wen / mem_waddr / mem_wdata  in  1/5/32  MEM-stage result
- mem_pending  in  1  MEM holds a load whose data has not returned
- wb_wen / wb_waddr / wb_wdata  in  1/5/32  write-back write port
- stall_req  out  1  operand unavailable; decode must hold

## Operation
- Storage: array regs[1..31]; x0 not stored, always reads 0.
- Write: on rising edge, if rst_in=1 and rdy_in=1 and wb_wen=1 and wb_waddr!=0, regs[wb_waddr] <= wb_wdata. Writes to x0 discarded.
- Reset: rst_in=0 at a rising edge clears regs[1..31] to 0; any write that cycle is dropped.
- Read, per port p (independent, identical logic):
  - read_flag_p=0 or reg_read_p=0 -> read_data_p=0, no hazard contribution.
  - else priority: EX match (ex_wen, ex_waddr==addr) -> ex_wdata; else MEM match -> mem_wdata; else WB match -> wb_wdata; else regs[addr].
  - Matches on waddr=0 ignored at every level.
- Hazard: port p hazards if it is active and (EX match with ex_is_load=1) or (MEM match, no EX match, mem_pending=1). stall_req = hazard_1 | hazard_2. Data output during hazard is the selected (stale) value; decode must not consume it.
- rst_in=0: read_data_1/2=0, stall_req=0 regardless of inputs.
- rdy_in=0: reads and bypass still evaluate; only array update suppressed.

## Timing
- Read latency 0 cycles (combinational from address, flags, bypass inputs and array).
- WB write visible through bypass in cycle N, from array in cycle N+1.
- Simultaneous EX, MEM, WB writes to same register: read returns EX value; array receives WB value.
- Both ports same address: identical data and hazard.
- stall_req combinational; deasserts the cycle the blocking condition clears (load moves to MEM with data, or mem_pending drops).
- Reset outputs: read_data_1=0, read_data_2=0, stall_req=0; array all zero after first reset edge.
- Reset asserted mid-stall: stall_req drops immediately, array cleared at that edge.

## Structure
- Shared defines file: `ZeroWord, new `RegAddrBus (4:0), `RegBus (31:0), `RegNum (32); stall encoding stays with `STALL_ID.
- Sub-module regfile_bypass: one instance per read port; inputs address, flag, three stage triples, load/pending flags, array word; outputs data and hazard. Top holds array, write logic and reset.

## Test plan
- Reset then read x5 on both ports -> 0; write x0<=0xDEADBEEF via WB, read x0 -> 0.
- WB writes x3<=0x12345678 cycle N, read x3 same cycle -> 0x12345678 (bypass); cycle N+1 with wb_wen=0 -> 0x12345678 (array).
- EX x7=0x1, MEM x7=0x2, WB x7=0x3 same cycle; read x7 -> 0x1; next cycle no bypass, read x7 -> 0x3.
- ex_is_load=1, ex_waddr=9; port 2 reads x9 -> stall_req=1; port reads x10 only -> stall_req=0; mem_pending=1 for x9 in MEM -> stall_req=1 until dropped.
- rdy_in=0 with WB write x4<=0xAA; next cycle wb_wen=0 read x4 -> prior value (0).
- rst_in=0 during active stall -> stall_req=0 same cycle, all registers read 0 after edge.
